multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Moore-style finite state machine that sequences the 16-bit multi-cycle processor datapath.
- Consumes the 3-bit opcode (IR[15:13]) and drives every datapath control strobe each cycle.
- Adds run/idle gating, sticky halt and illegal-opcode detection, and a retired-instruction counter for bring-up and verification.

Parameters:
- CNT_WIDTH, 16: width of the instr_count counter.
- HALT_ON_ILLEGAL, 1: 1 = an illegal opcode traps to ILLEGAL (sticky); 0 = it is treated as a NOP.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- run  in  1  permit new instruction fetches.
- opcode  in  3  IR[15:13] from the datapath.
- ALUOp  out  2  ALU operation class.
- ALUSrcB  out  2  ALU B-input select.
- PCSource  out  2  PC next-value select.
- RegDst, MemtoReg, MemRead, MemWrite, IorD, RegWrite, IRWrite, PCWrite, PCWriteCond, ALUSrcA  out  1 each  datapath strobes.
- halted  out  1  sticky; a HALT instruction has been executed.
- illegal_op  out  1  sticky; an illegal opcode was decoded.
- instr_count  out  CNT_WIDTH  count of fetched instructions.
- state_dbg  out  4  current state encoding.

Behaviour:
- Reset is asynchronous, active-low. While reset_n=0 and on release:
  - state = IDLE; all control outputs, halted, illegal_op = 0; instr_count = 0.
- Control outputs decode combinationally from the state register only (pure Moore). Any output not listed for a state is 0.
- Opcodes:
  - 000 R-type, 001 LW, 010 SW, 011 BEQ, 100 J, 101 ADDI, 111 HALT.
  - 110 is illegal.
- opcode is sampled only in DECODE; IR is valid because it was loaded at the end of FETCH.
- States, outputs and transitions:
  - IDLE: no outputs. Goes to FETCH if run=1, else stays in IDLE.
  - FETCH: MemRead=1, IRWrite=1, ALUSrcB=01, PCWrite=1, PCSource=00. Goes to DECODE.
  - DECODE: ALUSrcB=11 (branch target precompute). Next state by opcode:
    - R-type → EXEC; LW/SW → MEMADDR; BEQ → BRANCH; J → JUMP; ADDI → ADDI_EX; HALT → HALT.
    - 110 → ILLEGAL if HALT_ON_ILLEGAL=1, else → WRAP.
  - MEMADDR: ALUSrcA=1, ALUSrcB=10. LW → MEMREAD; SW → MEMWRITE.
  - MEMREAD: MemRead=1, IorD=1. Goes to MEMWB.
  - MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. Goes to WRAP.
  - MEMWRITE: MemWrite=1, IorD=1. Goes to WRAP.
  - EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Goes to RWB.
  - RWB: RegWrite=1, RegDst=1, MemtoReg=0. Goes to WRAP.
  - BRANCH: ALUSrcA=1, ALUOp=01, PCWriteCond=1, PCSource=01. Goes to WRAP.
  - JUMP: PCWrite=1, PCSource=10. Goes to WRAP.
  - ADDI_EX: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Goes to ADDI_WB.
  - ADDI_WB: RegWrite=1, RegDst=0, MemtoReg=0. Goes to WRAP.
  - HALT: sets halted. Absorbing until reset.
  - ILLEGAL: sets illegal_op. Absorbing until reset.
  - WRAP: virtual; it takes no cycle. It resolves in the same cycle as the state that targets it: FETCH if run=1, else IDLE.
- Cycles per instruction, counting FETCH:
  - R-type 4, LW 5, SW 4, BEQ 3, J 3, ADDI 4, NOP (illegal, HALT_ON_ILLEGAL=0) 2.
  - HALT reaches the HALT state on cycle 3.
- run deasserted mid-instruction: the current instruction completes; the controller then parks in IDLE. run has no effect in other states.
- Mutual exclusion:
  - MemRead and MemWrite never both 1.
  - PCWrite and PCWriteCond never both 1.
  - IRWrite only in FETCH.
- instr_count increments by 1 every cycle state==FETCH. It wraps from all-ones to 0 with no flag. It is frozen in IDLE, HALT and ILLEGAL.
- Unreachable state encodings recover to IDLE on the next clock with all outputs 0.
- Reset asserted mid-instruction: immediate return to IDLE. The partial instruction is abandoned; PC/IR contents in the datapath are not this block's concern.

Decomposition:
- Package multicycle_ctrl_pkg holds:
  - opcode constants OPC_RTYPE..OPC_HALT;
  - state encodings (4-bit);
  - ALUOp constants ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNC=10;
  - ALUSrcB and PCSource select constants.
- One natural sub-module: ctrl_output_decode, the combinational state→strobe table. Verification can check this table exhaustively.
- The next-state logic, sticky flags and counter stay in multicycle_control.

Test Plan:
- Reset release, run=1, opcode=000: state sequence IDLE, FETCH, DECODE, EXEC, RWB, FETCH. EXEC drives ALUOp=10; RWB drives RegWrite=1, RegDst=1. instr_count = 2 at the second FETCH.
- opcode=001 then 010 back-to-back:
  - LW takes 5 cycles; MEMREAD has IorD=1, MemRead=1; MEMWB has MemtoReg=1.
  - SW takes 4 cycles; MemWrite=1 for exactly 1 cycle.
  - MemRead and MemWrite are never high together.
- opcode=011, then 100: BRANCH drives PCWriteCond=1, PCSource=01, ALUOp=01 for 1 cycle; JUMP drives PCWrite=1, PCSource=10. Each instruction takes 3 cycles.
- opcode=111: halted=1 from cycle 3 onward; instr_count freezes; all strobes stay 0 for 20 cycles; reset_n pulse returns to IDLE with halted=0.
- opcode=110: with HALT_ON_ILLEGAL=1, illegal_op=1 sticky. With HALT_ON_ILLEGAL=0, it returns to FETCH after DECODE, with illegal_op=0 and no RegWrite/MemWrite.
- Drop run during EXEC of an R-type: RWB completes, then IDLE with all outputs 0. Assert reset_n=0 asynchronously mid-MEMREAD: outputs go to 0 immediately, without a clock edge.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle controller: opcodes, FSM states, datapath selects.
// No logic; constants only.
// Backpressure: n/a.
package multicycle_ctrl_pkg;

    localparam logic [2:0] OPC_RTYPE = 3'b000;
    localparam logic [2:0] OPC_LW    = 3'b001;
    localparam logic [2:0] OPC_SW    = 3'b010;
    localparam logic [2:0] OPC_BEQ   = 3'b011;
    localparam logic [2:0] OPC_J     = 3'b100;
    localparam logic [2:0] OPC_ADDI  = 3'b101;
    localparam logic [2:0] OPC_ILL   = 3'b110;
    localparam logic [2:0] OPC_HALT  = 3'b111;

    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_BRTGT = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Encoding 4'hF is deliberately unused; it recovers to IDLE.
    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADDR  = 4'd3,
        S_MEMREAD  = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWRITE = 4'd6,
        S_EXEC     = 4'd7,
        S_RWB      = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_ADDI_EX  = 4'd11,
        S_ADDI_WB  = 4'd12,
        S_HALT     = 4'd13,
        S_ILLEGAL  = 4'd14
    } state_t;

endpackage

// File: rtl/ctrl_output_decode.sv
// Pure combinational state -> datapath strobe table (Moore outputs).
// Latency: zero (combinational from the state register).
// Backpressure: none.
module ctrl_output_decode
    import multicycle_ctrl_pkg::*;
(
    input  logic [3:0] state,
    output logic [1:0] ALUOp,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IorD,
    output logic       RegWrite,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       ALUSrcA
);

    always_comb begin
        ALUOp       = ALUOP_ADD;
        ALUSrcB     = SRCB_REG;
        PCSource    = PCSRC_ALU;
        RegDst      = 1'b0;
        MemtoReg    = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IorD        = 1'b0;
        RegWrite    = 1'b0;
        IRWrite     = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        ALUSrcA     = 1'b0;
        case (state)
            S_FETCH: begin
                MemRead  = 1'b1;
                IRWrite  = 1'b1;
                ALUSrcB  = SRCB_FOUR;
                PCWrite  = 1'b1;
                PCSource = PCSRC_ALU;
            end
            S_DECODE:   ALUSrcB = SRCB_BRTGT;
            S_MEMADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMREAD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_MEMWRITE: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_FUNC;
            end
            S_RWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = ALUOP_SUB;
                PCWriteCond = 1'b1;
                PCSource    = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = PCSRC_JUMP;
            end
            S_ADDI_EX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            S_ADDI_WB:  RegWrite = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Moore FSM sequencing the 16-bit multi-cycle datapath, with run gating, sticky halt/illegal and fetch counter.
// Latency: outputs follow the state register; opcode is sampled in DECODE only.
// Backpressure: run=0 parks the FSM in IDLE after the current instruction retires.
module multicycle_control
    import multicycle_ctrl_pkg::*;
#(
    parameter int CNT_WIDTH       = 16,
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 run,
    input  logic [2:0]           opcode,
    output logic [1:0]           ALUOp,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           PCSource,
    output logic                 RegDst,
    output logic                 MemtoReg,
    output logic                 MemRead,
    output logic                 MemWrite,
    output logic                 IorD,
    output logic                 RegWrite,
    output logic                 IRWrite,
    output logic                 PCWrite,
    output logic                 PCWriteCond,
    output logic                 ALUSrcA,
    output logic                 halted,
    output logic                 illegal_op,
    output logic [CNT_WIDTH-1:0] instr_count,
    output logic [3:0]           state_dbg
);

    state_t state, next_state, wrap_state;
    logic   mem_is_load;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            mem_is_load <= 1'b0;
            instr_count <= '0;
        end else begin
            state <= next_state;
            if (state == S_DECODE)
                mem_is_load <= (opcode == OPC_LW);
            // Counted on entry so the FETCH cycle already shows its own instruction.
            if (next_state == S_FETCH)
                instr_count <= instr_count + CNT_WIDTH'(1);
        end
    end

    // WRAP is not a real state: end-of-instruction resolves straight to FETCH or IDLE.
    assign wrap_state = run ? S_FETCH : S_IDLE;

    always_comb begin
        next_state = S_IDLE;
        case (state)
            S_IDLE:   next_state = run ? S_FETCH : S_IDLE;
            S_FETCH:  next_state = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OPC_RTYPE:       next_state = S_EXEC;
                    OPC_LW, OPC_SW:  next_state = S_MEMADDR;
                    OPC_BEQ:         next_state = S_BRANCH;
                    OPC_J:           next_state = S_JUMP;
                    OPC_ADDI:        next_state = S_ADDI_EX;
                    OPC_HALT:        next_state = S_HALT;
                    default:         next_state = HALT_ON_ILLEGAL ? S_ILLEGAL : wrap_state;
                endcase
            end
            S_MEMADDR:  next_state = mem_is_load ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  next_state = S_MEMWB;
            S_EXEC:     next_state = S_RWB;
            S_ADDI_EX:  next_state = S_ADDI_WB;
            S_MEMWB, S_MEMWRITE, S_RWB, S_BRANCH, S_JUMP, S_ADDI_WB:
                        next_state = wrap_state;
            S_HALT:     next_state = S_HALT;
            S_ILLEGAL:  next_state = S_ILLEGAL;
            default:    next_state = S_IDLE;
        endcase
    end

    // HALT and ILLEGAL are absorbing, so the state itself holds the sticky flags.
    assign halted     = (state == S_HALT);
    assign illegal_op = (state == S_ILLEGAL);
    assign state_dbg  = state;

    ctrl_output_decode u_decode (
        .state       (state),
        .ALUOp       (ALUOp),
        .ALUSrcB     (ALUSrcB),
        .PCSource    (PCSource),
        .RegDst      (RegDst),
        .MemtoReg    (MemtoReg),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .IorD        (IorD),
        .RegWrite    (RegWrite),
        .IRWrite     (IRWrite),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .ALUSrcA     (ALUSrcA)
    );

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: one trapping instance and one NOP-on-illegal instance.
// Checks state sequence, strobes, counters and sticky flags against hand-derived constants.
module tb_multicycle_control;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        run = 1'b0;
    logic [2:0]  opcode = 3'b000;

    logic [1:0]  a_aluop, a_srcb, a_pcsrc, b_aluop, b_srcb, b_pcsrc;
    logic        a_regdst, a_memtoreg, a_memread, a_memwrite, a_iord, a_regwrite;
    logic        a_irwrite, a_pcwrite, a_pcwritecond, a_alusrca, a_halted, a_illegal;
    logic        b_regdst, b_memtoreg, b_memread, b_memwrite, b_iord, b_regwrite;
    logic        b_irwrite, b_pcwrite, b_pcwritecond, b_alusrca, b_halted, b_illegal;
    logic [15:0] a_count, b_count;
    logic [3:0]  a_state, b_state;
    logic [15:0] a_ctrl, b_ctrl;

    int n_checks = 0;
    int n_errors = 0;

    // Expected strobe vectors: {ALUOp, ALUSrcB, PCSource,
    //   RegDst, MemtoReg, MemRead, MemWrite, IorD, RegWrite, IRWrite, PCWrite, PCWriteCond, ALUSrcA}
    localparam logic [15:0] C_NONE   = {2'b00, 2'b00, 2'b00, 10'b0000000000};
    localparam logic [15:0] C_FETCH  = {2'b00, 2'b01, 2'b00, 10'b0010001100};
    localparam logic [15:0] C_DECODE = {2'b00, 2'b11, 2'b00, 10'b0000000000};
    localparam logic [15:0] C_MADDR  = {2'b00, 2'b10, 2'b00, 10'b0000000001};
    localparam logic [15:0] C_MREAD  = {2'b00, 2'b00, 2'b00, 10'b0010100000};
    localparam logic [15:0] C_MWB    = {2'b00, 2'b00, 2'b00, 10'b0100010000};
    localparam logic [15:0] C_MWRITE = {2'b00, 2'b00, 2'b00, 10'b0001100000};
    localparam logic [15:0] C_EXEC   = {2'b10, 2'b00, 2'b00, 10'b0000000001};
    localparam logic [15:0] C_RWB    = {2'b00, 2'b00, 2'b00, 10'b1000010000};
    localparam logic [15:0] C_BRANCH = {2'b01, 2'b00, 2'b01, 10'b0000000011};
    localparam logic [15:0] C_JUMP   = {2'b00, 2'b00, 2'b10, 10'b0000000100};
    localparam logic [15:0] C_ADDIEX = {2'b00, 2'b10, 2'b00, 10'b0000000001};
    localparam logic [15:0] C_ADDIWB = {2'b00, 2'b00, 2'b00, 10'b0000010000};

    localparam logic [3:0] ST_IDLE = 4'd0, ST_FETCH = 4'd1, ST_DECODE = 4'd2, ST_MADDR = 4'd3,
                           ST_MREAD = 4'd4, ST_MWB = 4'd5, ST_MWRITE = 4'd6, ST_EXEC = 4'd7,
                           ST_RWB = 4'd8, ST_BRANCH = 4'd9, ST_JUMP = 4'd10, ST_ADDIEX = 4'd11,
                           ST_ADDIWB = 4'd12, ST_HALT = 4'd13, ST_ILL = 4'd14;

    assign a_ctrl = {a_aluop, a_srcb, a_pcsrc, a_regdst, a_memtoreg, a_memread, a_memwrite,
                     a_iord, a_regwrite, a_irwrite, a_pcwrite, a_pcwritecond, a_alusrca};
    assign b_ctrl = {b_aluop, b_srcb, b_pcsrc, b_regdst, b_memtoreg, b_memread, b_memwrite,
                     b_iord, b_regwrite, b_irwrite, b_pcwrite, b_pcwritecond, b_alusrca};

    always #5 clock = ~clock;

    multicycle_control #(.CNT_WIDTH(16), .HALT_ON_ILLEGAL(1'b1)) dut (
        .clock(clock), .reset_n(reset_n), .run(run), .opcode(opcode),
        .ALUOp(a_aluop), .ALUSrcB(a_srcb), .PCSource(a_pcsrc),
        .RegDst(a_regdst), .MemtoReg(a_memtoreg), .MemRead(a_memread), .MemWrite(a_memwrite),
        .IorD(a_iord), .RegWrite(a_regwrite), .IRWrite(a_irwrite), .PCWrite(a_pcwrite),
        .PCWriteCond(a_pcwritecond), .ALUSrcA(a_alusrca), .halted(a_halted),
        .illegal_op(a_illegal), .instr_count(a_count), .state_dbg(a_state)
    );

    multicycle_control #(.CNT_WIDTH(16), .HALT_ON_ILLEGAL(1'b0)) dut_nop (
        .clock(clock), .reset_n(reset_n), .run(run), .opcode(opcode),
        .ALUOp(b_aluop), .ALUSrcB(b_srcb), .PCSource(b_pcsrc),
        .RegDst(b_regdst), .MemtoReg(b_memtoreg), .MemRead(b_memread), .MemWrite(b_memwrite),
        .IorD(b_iord), .RegWrite(b_regwrite), .IRWrite(b_irwrite), .PCWrite(b_pcwrite),
        .PCWriteCond(b_pcwritecond), .ALUSrcA(b_alusrca), .halted(b_halted),
        .illegal_op(b_illegal), .instr_count(b_count), .state_dbg(b_state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock, sample 1 time unit later, check state, strobes and invariants.
    task automatic step_chk(input string tag, input logic [3:0] st, input logic [15:0] ctrl);
        @(posedge clock);
        #1;
        check({tag, "_state"}, 32'(a_state), 32'(st));
        check({tag, "_ctrl"}, 32'(a_ctrl), 32'(ctrl));
        check({tag, "_rd_wr_excl"}, 32'(a_memread & a_memwrite), 32'd0);
        check({tag, "_pcw_excl"}, 32'(a_pcwrite & a_pcwritecond), 32'd0);
        check({tag, "_irw_fetch"}, 32'(a_irwrite & (a_state != ST_FETCH)), 32'd0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        check("rst_state", 32'(a_state), 32'(ST_IDLE));
        check("rst_ctrl", 32'(a_ctrl), 32'(C_NONE));
        check("rst_flags", 32'({a_halted, a_illegal, b_halted, b_illegal}), 32'd0);
        check("rst_count", 32'(a_count), 32'd0);
        reset_n = 1'b1;
    endtask

    initial begin
        run = 1'b1;
        opcode = 3'b000;
        do_reset();

        // R-type
        step_chk("r_fetch", ST_FETCH, C_FETCH);
        check("r_cnt1", 32'(a_count), 32'd1);
        step_chk("r_decode", ST_DECODE, C_DECODE);
        step_chk("r_exec", ST_EXEC, C_EXEC);
        step_chk("r_rwb", ST_RWB, C_RWB);
        step_chk("lw_fetch", ST_FETCH, C_FETCH);
        check("r_cnt2", 32'(a_count), 32'd2);

        // LW (5 cycles) then SW (4 cycles)
        opcode = 3'b001;
        step_chk("lw_decode", ST_DECODE, C_DECODE);
        step_chk("lw_maddr", ST_MADDR, C_MADDR);
        step_chk("lw_mread", ST_MREAD, C_MREAD);
        step_chk("lw_mwb", ST_MWB, C_MWB);
        step_chk("sw_fetch", ST_FETCH, C_FETCH);
        opcode = 3'b010;
        step_chk("sw_decode", ST_DECODE, C_DECODE);
        step_chk("sw_maddr", ST_MADDR, C_MADDR);
        step_chk("sw_mwrite", ST_MWRITE, C_MWRITE);
        step_chk("beq_fetch", ST_FETCH, C_FETCH);
        check("sw_cnt", 32'(a_count), 32'd4);

        // BEQ, J, ADDI
        opcode = 3'b011;
        step_chk("beq_decode", ST_DECODE, C_DECODE);
        step_chk("beq_branch", ST_BRANCH, C_BRANCH);
        step_chk("j_fetch", ST_FETCH, C_FETCH);
        opcode = 3'b100;
        step_chk("j_decode", ST_DECODE, C_DECODE);
        step_chk("j_jump", ST_JUMP, C_JUMP);
        step_chk("addi_fetch", ST_FETCH, C_FETCH);
        opcode = 3'b101;
        step_chk("addi_decode", ST_DECODE, C_DECODE);
        step_chk("addi_ex", ST_ADDIEX, C_ADDIEX);
        step_chk("addi_wb", ST_ADDIWB, C_ADDIWB);
        step_chk("r2_fetch", ST_FETCH, C_FETCH);
        check("addi_cnt", 32'(a_count), 32'd7);

        // Drop run during EXEC: RWB completes, then park in IDLE
        opcode = 3'b000;
        step_chk("r2_decode", ST_DECODE, C_DECODE);
        step_chk("r2_exec", ST_EXEC, C_EXEC);
        run = 1'b0;
        step_chk("r2_rwb", ST_RWB, C_RWB);
        step_chk("park_idle", ST_IDLE, C_NONE);
        step_chk("park_idle2", ST_IDLE, C_NONE);
        check("park_cnt", 32'(a_count), 32'd7);

        // Async reset mid-MEMREAD
        run = 1'b1;
        opcode = 3'b001;
        step_chk("ar_fetch", ST_FETCH, C_FETCH);
        check("ar_cnt", 32'(a_count), 32'd8);
        step_chk("ar_decode", ST_DECODE, C_DECODE);
        step_chk("ar_maddr", ST_MADDR, C_MADDR);
        step_chk("ar_mread", ST_MREAD, C_MREAD);
        #2;
        reset_n = 1'b0;
        #1;
        check("ar_state", 32'(a_state), 32'(ST_IDLE));
        check("ar_ctrl", 32'(a_ctrl), 32'(C_NONE));
        check("ar_count", 32'(a_count), 32'd0);
        do_reset();

        // Illegal opcode: trap on dut, NOP on dut_nop
        opcode = 3'b110;
        step_chk("ill_fetch", ST_FETCH, C_FETCH);
        step_chk("ill_decode", ST_DECODE, C_DECODE);
        for (int i = 0; i < 4; i++) begin
            step_chk("ill_trap", ST_ILL, C_NONE);
            check("ill_flag", 32'(a_illegal), 32'd1);
            check("ill_cnt", 32'(a_count), 32'd1);
            check("nop_flag", 32'(b_illegal), 32'd0);
            check("nop_wr", 32'({b_regwrite, b_memwrite}), 32'd0);
            if (i == 0) begin
                check("nop_state", 32'(b_state), 32'(ST_FETCH));
                check("nop_ctrl", 32'(b_ctrl), 32'(C_FETCH));
                check("nop_cnt", 32'(b_count), 32'd2);
            end
        end
        do_reset();

        // HALT: reached on cycle 3, sticky, counter frozen, strobes quiet
        opcode = 3'b111;
        step_chk("h_fetch", ST_FETCH, C_FETCH);
        step_chk("h_decode", ST_DECODE, C_DECODE);
        check("h_not_yet", 32'(a_halted), 32'd0);
        for (int i = 0; i < 20; i++) begin
            step_chk("h_halt", ST_HALT, C_NONE);
            check("h_flag", 32'(a_halted), 32'd1);
            check("h_cnt", 32'(a_count), 32'd1);
        end
        do_reset();
        check("h_cleared", 32'(a_halted), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
